muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  64  operand A, from register-file ReadData1.
- rs2_data  in  64  operand B, from register-file ReadData2.
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and ADJ.
- done  out  1  single-cycle result-valid pulse; drives the register-file write enable.
- result  out  64  result word; drives the register-file write data.
- rd_out  out  5  destination index; drives the register-file write address.

Function
REQ-002 The FSM SHALL have four states: IDLE, CALC, ADJ, DONE.
REQ-003 Transitions SHALL be:
- IDLE->CALC on start=1.
- CALC->ADJ after 64 CALC cycles.
- ADJ->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-004 On the accepting edge E0, the block SHALL latch op, rs1_data, rs2_data and rd_in; later input changes SHALL have no effect until the next acceptance.
REQ-005 The block SHALL ignore start in CALC, ADJ and DONE, with no queuing.
REQ-006 done SHALL be 1 only in DONE: exactly one cycle, entered at edge E0+65, for every op including special cases.
REQ-007 Throughput SHALL be one operation per 67 cycles minimum; start is accepted in the cycle after DONE at the earliest.
REQ-008 result and rd_out SHALL update at edge E0+65 and hold until the next result update or reset.
REQ-009 Operand signedness SHALL be:
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU, DIVU, REMU: both unsigned.
REQ-010 Multiply SHALL use 64 shift-add iterations on unsigned magnitudes into a 128-bit product, one bit per CALC cycle.
REQ-011 In ADJ, multiply SHALL two's-complement negate the 128-bit product when the operand signs differ.
REQ-012 Multiply result selection SHALL be: MUL returns product[63:0]; MULH, MULHSU and MULHU return product[127:64].
REQ-013 Divide SHALL use 64 restoring iterations on magnitudes, one quotient bit per CALC cycle.
REQ-014 In ADJ, the quotient SHALL be negated when the signs differ (signed ops), and the remainder SHALL take the dividend's sign.
REQ-015 Divide-by-zero (rs2=0): DIV/DIVU SHALL return 0xFFFF_FFFF_FFFF_FFFF; REM/REMU SHALL return rs1 unchanged; latency unchanged.
REQ-016 Signed overflow (DIV/REM with rs1=0x8000_0000_0000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF): DIV SHALL return 0x8000_0000_0000_0000; REM SHALL return 0; latency unchanged.
REQ-017 The iteration counter SHALL be 6 bits, counting 0..63; wrap from 63 to 0 coincides with CALC->ADJ.
REQ-018 No output SHALL depend combinationally on any input; all outputs are registered or decoded from state.

Reset
REQ-019 reset=1 at a rising edge SHALL force:
- state IDLE; busy=0, done=0;
- result=0, rd_out=0;
- counter and datapath registers cleared.
REQ-020 reset SHALL take priority over start in the same cycle; that start is not accepted.
REQ-021 Reset during CALC, ADJ or DONE SHALL discard the in-flight operation: no done pulse, no result update.
REQ-022 A start in the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-023 MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (-3), rd_in=5 -> done exactly at E0+65 for 1 cycle; result=0xFFFF_FFFF_FFFF_FFEB; rd_out=5.
REQ-024 MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-025 MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
REQ-026 Signed division, rs1=-20, rs2=6:
- DIV -> result=0xFFFF_FFFF_FFFF_FFFD (-3).
- REM -> result=0xFFFF_FFFF_FFFF_FFFE (-2).
REQ-027 Special cases:
- DIVU 5/0 -> result=0xFFFF_FFFF_FFFF_FFFF.
- REMU 5/0 -> result=5.
- DIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000.
- REM of the same operands -> result=0.
REQ-028 Reset and busy-start handling:
- start pulse during CALC -> ignored; first operation completes unaltered.
- reset at CALC cycle 30 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
- start in the cycle after reset deasserts -> accepted; correct result at +65.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 64-bit RV64M multiply/divide; ports clk, reset, start, op, rs1_data, rs2_data, rd_in -> busy, done, result, rd_out
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  rd_out
);
  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;
  state_t state, next;
  logic [5:0]   cnt;
  logic [2:0]   op_r;
  logic [4:0]   rd_r;
  logic [63:0]  m;
  logic [127:0] acc;
  logic         neg_q, neg_r;
  logic         s1, s2, n1, n2;
  logic [63:0]  mag1, mag2;
  logic [64:0]  sum, t, diff;
  logic         ge;
  logic [127:0] mul_next, div_next, prod;
  logic [63:0]  res;
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (start ? CALC : IDLE) :
           state == CALC ? (cnt == 6'd63 ? ADJ : CALC) :
           state == ADJ  ? DONE : IDLE;
    busy = state == CALC || state == ADJ;
    done = state == DONE;
  end
  // Signedness decode: rs2 is unsigned for MULHSU/MULHU and the U divides.
  always_comb begin
    s1   = op[2] ? !op[0] : !(op[1] & op[0]);
    s2   = op[2] ? !op[0] : !op[1];
    n1   = s1 & rs1_data[63];
    n2   = s2 & rs2_data[63];
    mag1 = n1 ? -rs1_data : rs1_data;
    mag2 = n2 ? -rs2_data : rs2_data;
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum      = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, m} : 65'd0);
    mul_next = {sum, acc[63:1]};
    t        = {acc[127:64], acc[63]};
    ge       = t >= {1'b0, m};
    diff     = t - {1'b0, m};
    div_next = {ge ? diff[63:0] : t[63:0], acc[62:0], ge};
    prod     = neg_q ? -acc : acc;
    res      = op_r[2] ? (op_r[1] ? (neg_r ? -acc[127:64] : acc[127:64])
                                  : (neg_q ? -acc[63:0] : acc[63:0]))
                       : (op_r[1:0] == 2'b00 ? prod[63:0] : prod[127:64]);
  end
  // Divide-by-zero keeps the all-ones quotient unsigned; signed overflow falls out of the magnitude path.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_r   <= '0;
      rd_r   <= '0;
      m      <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (state == IDLE && start) begin
      cnt   <= '0;
      op_r  <= op;
      rd_r  <= rd_in;
      m     <= op[2] ? mag2 : mag1;
      acc   <= {64'd0, op[2] ? mag1 : mag2};
      neg_q <= (n1 ^ n2) & !(op[2] && rs2_data == 64'd0);
      neg_r <= n1;
    end else if (state == CALC) begin
      acc <= op_r[2] ? div_next : mul_next;
      cnt <= cnt + 6'd1;
    end else if (state == ADJ) begin
      result <= res;
      rd_out <= rd_r;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        clk = 0, reset = 1, start = 0;
  logic [2:0]  op = 0;
  logic [63:0] rs1_data = 0, rs2_data = 0;
  logic [4:0]  rd_in = 0;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  rd_out;
  int          total = 0, bad = 0;
  logic [63:0] last = 0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  muldiv_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .rs1_data(rs1_data),
                   .rs2_data(rs2_data), .rd_in(rd_in), .busy(busy), .done(done),
                   .result(result), .rd_out(rd_out));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    logic signed [63:0] xa, xb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    xa = a;
    xb = b;
    case (o)
      3'd0: begin p = sa * sb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: return b == 0 ? ONES : (a == MIN && b == ONES) ? MIN : 64'(xa / xb);
      3'd5: return b == 0 ? ONES : a / b;
      3'd6: return b == 0 ? a : (a == MIN && b == ONES) ? 64'd0 : 64'(xa % xb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return MIN;
      2: return ONES;
      3: return 64'($urandom_range(0, 100));
      4: return -64'($urandom_range(1, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  // Starts one op, scrambles inputs after acceptance, optionally pokes start mid-flight and in DONE.
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, input bit poke);
    logic [63:0] exp;
    int first, nd;
    exp = model(o, a, b);
    op = o; rs1_data = a; rs2_data = b; rd_in = d; start = 1;
    @(posedge clk); #1;
    start = 0; op = 3'($urandom); rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom}; rd_in = 5'($urandom);
    first = 0; nd = 0;
    for (int k = 1; k <= 66; k++) begin
      if (poke) start = (k == 10 || k == 66);
      @(posedge clk); #1;
      if (k == 1) check("busy_calc", 64'(busy), 64'd1);
      if (k == 64) check("result_hold", result, last);
      if (done) begin
        nd++;
        if (first == 0) first = k;
      end
    end
    start = 0;
    check("latency", 64'(first), 64'd65);
    check("done_pulses", 64'(nd), 64'd1);
    check($sformatf("result op=%0d", o), result, exp);
    check("rd_out", 64'(rd_out), 64'(d));
    check("busy_idle", 64'(busy), 64'd0);
    last = exp;
  endtask
  initial begin
    int nd;
    reset = 1; start = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_rd", 64'(rd_out), 64'd0);
    reset = 0; start = 0;
    run_op(3'd0, 64'd7, -64'd3, 5'd5, 1'b0);
    run_op(3'd3, ONES, ONES, 5'd1, 1'b0);
    run_op(3'd2, ONES, 64'd2, 5'd2, 1'b0);
    run_op(3'd4, -64'd20, 64'd6, 5'd3, 1'b1);
    run_op(3'd6, -64'd20, 64'd6, 5'd4, 1'b0);
    run_op(3'd5, 64'd5, 64'd0, 5'd6, 1'b0);
    run_op(3'd7, 64'd5, 64'd0, 5'd7, 1'b0);
    run_op(3'd4, MIN, ONES, 5'd8, 1'b0);
    run_op(3'd6, MIN, ONES, 5'd9, 1'b0);
    run_op(3'd4, -64'd7, 64'd0, 5'd10, 1'b0);
    run_op(3'd1, MIN, MIN, 5'd11, 1'b0);
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), pick(), pick(), 5'($urandom), bit'($urandom_range(0, 1)));
    op = 3'd0; rs1_data = 64'd9; rs2_data = 64'd9; rd_in = 5'd12; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    last = 0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_rd", 64'(rd_out), 64'd0);
    nd = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);
    reset = 1; start = 1;
    @(posedge clk); #1;
    reset = 0; start = 0;
    @(posedge clk); #1;
    check("rst_prio_busy", 64'(busy), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    run_op(3'd4, -64'd100, 64'd7, 5'd13, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
